tile_position_ctrl: RTL and testbench
=====================================

// Module: tile_position_ctrl
// PURPOSE
//  Upstream stage of the tile renderer. Debounces five raw push-buttons and holds the tile
//  grid position (x,y) and tile colour consumed by the tile-to-RGB stage. Moves and colour
//  changes are committed once per frame, at the start of vertical blanking, so the drawn
//  tile never tears mid-frame. Grid is 20x15 tiles of 32x32 px on a 640x480 display.
// PARAMETERS
//  DEBOUNCE_CYCLES  500000  stable cycles before a button state is accepted (10 ms @ 50 MHz); must be < 2^20
//  GRID_W           20      tile columns; x range 0..GRID_W-1
//  GRID_H           15      tile rows; y range 0..GRID_H-1
//  V_UPDATE         480     vcount value that marks the frame commit point (first blank line)
//  COLOR_INIT       8'hE0   colour after reset (RRRGGGBB)
//  COLOR_STEP       8'h25   increment applied per colour press
// PORTS
//  clk           in   1   system clock
//  rst_n         in   1   asynchronous active-low reset
//  btn_up        in   1   raw button, async to clk, active-high; y-1
//  btn_down      in   1   raw button; y+1
//  btn_left      in   1   raw button; x-1
//  btn_right     in   1   raw button; x+1
//  btn_color     in   1   raw button; advance colour
//  vcount        in   11  current line from the VGA timing generator
//  x             out  5   tile column, registered
//  y             out  4   tile row, registered
//  color         out  8   tile colour, registered
//  frame_update  out  1   one-cycle pulse in the commit cycle (every frame, whether or not anything changed)
// BEHAVIOUR
//  Reset (async assert, sync-release use): x=0, y=0, color=COLOR_INIT, frame_update=0,
//   all synchronisers/debounce counters/debounced states/pending flags cleared.
//  Per button: 2-FF synchroniser -> debouncer. Debouncer: 20-bit counter increments while the
//   synced input differs from the debounced state, clears when equal; on reaching
//   DEBOUNCE_CYCLES the debounced state toggles and the counter clears. Press latency =
//   2 + DEBOUNCE_CYCLES cycles from a clean edge.
//  Rising edge of a debounced state sets that button's 1-bit pending flag. Repeat presses
//   within one frame collapse to one step. Releases are ignored.
//  Commit point: the cycle in which vcount==V_UPDATE and vcount registered in the previous cycle !=V_UPDATE
//   (one commit per frame even though vcount holds V_UPDATE for a whole line).
//  In the commit cycle: frame_update=1; x/y/color update from the pending flags; all flags
//   clear. A debounced edge arriving in the commit cycle itself sets its flag for the NEXT frame
//   (set beats clear).
//  Move rules (registered, visible the cycle after the commit):
//   left only: x = (x==0) ? GRID_W-1 : x-1;  right only: x = (x==GRID_W-1) ? 0 : x+1
//   up only:   y = (y==0) ? GRID_H-1 : y-1;  down only:  y = (y==GRID_H-1) ? 0 : y+1
//   left+right pending together -> x unchanged; up+down together -> y unchanged.
//   Horizontal and vertical moves in the same frame both apply (diagonal step).
//  Colour: next = color + COLOR_STEP (mod 256); if next==8'h00 then color=COLOR_STEP,
//   so the tile never becomes black. Applied once per frame regardless of press count.
//  x,y never leave the grid range; out-of-range values are unreachable after reset.
//  Reset asserted mid-debounce or with flags pending: everything is discarded; no move
//   occurs at the next commit.
// TESTING (sim with DEBOUNCE_CYCLES=4)
//  Reset: rst_n=0 mid-run -> x=0, y=0, color=8'hE0, frame_update=0 immediately (async).
//  Bounce: btn_right toggles every 2 cycles for 40 cycles, then low -> no pending flag, x stays 0.
//  Clean btn_right press, then vcount steps 479->480 -> frame_update pulses 1 cycle, x=1 next cycle;
//   vcount held at 480 for 800 cycles -> no second pulse.
//  Wrap: x=0, y=0, left+up pressed in one frame -> x=19, y=14 after the commit; then right+down -> 0,0.
//  Conflict/collapse: left+right in one frame -> x unchanged; right pressed 3x in one frame -> x+1 only.
//  Colour: 7 frames of btn_color from reset -> E0,05,2A,4F,74,99,BE,E3; start at 8'hDB -> next 8'h25 (zero skipped).

Source files
------------

// File: rtl/tile_position_ctrl.sv
// Debounces five push-buttons and holds the tile grid position and colour for the renderer.
// Latency: press visible 2+DEBOUNCE_CYCLES cycles after a clean edge, committed at the next frame point.
// No backpressure: presses collapse into per-button pending flags consumed once per frame.
module tile_position_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned GRID_W          = 20,
    parameter int unsigned GRID_H          = 15,
    parameter int unsigned V_UPDATE        = 480,
    parameter logic [7:0]  COLOR_INIT      = 8'hE0,
    parameter logic [7:0]  COLOR_STEP      = 8'h25
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_color,
    input  logic [10:0] vcount,
    output logic [4:0]  x,
    output logic [3:0]  y,
    output logic [7:0]  color,
    output logic        frame_update
);

    localparam int unsigned BTN_N = 5;
    localparam int unsigned B_UP    = 0;
    localparam int unsigned B_DOWN  = 1;
    localparam int unsigned B_LEFT  = 2;
    localparam int unsigned B_RIGHT = 3;
    localparam int unsigned B_COLOR = 4;

    localparam logic [19:0] DB_LAST = 20'(DEBOUNCE_CYCLES - 1);
    localparam logic [10:0] V_UPD   = 11'(V_UPDATE);
    localparam logic [4:0]  X_MAX   = 5'(GRID_W - 1);
    localparam logic [3:0]  Y_MAX   = 4'(GRID_H - 1);

    logic [BTN_N-1:0] btn_raw;
    logic [BTN_N-1:0] sync1_q, sync2_q;
    logic [BTN_N-1:0] db_q, db_d;
    logic [BTN_N-1:0] rise;
    logic [BTN_N-1:0] pend_q, pend_d;
    logic [19:0]      cnt_q [BTN_N];
    logic [19:0]      cnt_d [BTN_N];

    logic [10:0] vcount_q;
    logic        commit;

    logic [4:0] x_q, x_d;
    logic [3:0] y_q, y_d;
    logic [7:0] color_q, color_d;
    logic [7:0] color_sum;

    assign btn_raw = {btn_color, btn_right, btn_left, btn_down, btn_up};

    // Counter only runs while the synced input disagrees with the accepted state;
    // the last disagreeing cycle flips the state, so the counter returns to zero.
    always_comb begin
        for (int i = 0; i < BTN_N; i++) begin
            cnt_d[i] = '0;
            db_d[i]  = db_q[i];
            rise[i]  = 1'b0;
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == DB_LAST) begin
                    db_d[i] = ~db_q[i];
                    rise[i] = ~db_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 20'd1;
                end
            end
        end
    end

    // vcount_q resets to the commit line so reset release never fakes a commit.
    assign commit = (vcount == V_UPD) && (vcount_q != V_UPD);

    // An edge landing in the commit cycle survives the clear and counts for the next frame.
    assign pend_d = (commit ? '0 : pend_q) | rise;

    assign color_sum = color_q + COLOR_STEP;

    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        color_d = color_q;
        if (commit) begin
            if (pend_q[B_LEFT] && !pend_q[B_RIGHT]) begin
                x_d = (x_q == 5'd0) ? X_MAX : x_q - 5'd1;
            end else if (pend_q[B_RIGHT] && !pend_q[B_LEFT]) begin
                x_d = (x_q == X_MAX) ? 5'd0 : x_q + 5'd1;
            end
            if (pend_q[B_UP] && !pend_q[B_DOWN]) begin
                y_d = (y_q == 4'd0) ? Y_MAX : y_q - 4'd1;
            end else if (pend_q[B_DOWN] && !pend_q[B_UP]) begin
                y_d = (y_q == Y_MAX) ? 4'd0 : y_q + 4'd1;
            end
            if (pend_q[B_COLOR]) begin
                color_d = (color_sum == 8'h00) ? COLOR_STEP : color_sum;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            db_q     <= '0;
            pend_q   <= '0;
            vcount_q <= V_UPD;
            x_q      <= 5'd0;
            y_q      <= 4'd0;
            color_q  <= COLOR_INIT;
            for (int i = 0; i < BTN_N; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q  <= btn_raw;
            sync2_q  <= sync1_q;
            db_q     <= db_d;
            pend_q   <= pend_d;
            vcount_q <= vcount;
            x_q      <= x_d;
            y_q      <= y_d;
            color_q  <= color_d;
            for (int i = 0; i < BTN_N; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign x            = x_q;
    assign y            = y_q;
    assign color        = color_q;
    assign frame_update = commit;

endmodule

// File: tb/tb_tile_position_ctrl.sv
// Directed bench for tile_position_ctrl with a short debounce window.
module tb_tile_position_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        btn_up, btn_down, btn_left, btn_right, btn_color;
    logic [10:0] vcount;
    logic [4:0]  x;
    logic [3:0]  y;
    logic [7:0]  color;
    logic        frame_update;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    tile_position_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_up       (btn_up),
        .btn_down     (btn_down),
        .btn_left     (btn_left),
        .btn_right    (btn_right),
        .btn_color    (btn_color),
        .vcount       (vcount),
        .x            (x),
        .y            (y),
        .color        (color),
        .frame_update (frame_update)
    );

    typedef struct {
        logic l, r, u, d, c;
        int   ex, ey, ec;
    } vec_t;

    vec_t tbl [9];
    logic [7:0] col_seq [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic l, r, u, d, c);
        btn_left = l; btn_right = r; btn_up = u; btn_down = d; btn_color = c;
        tick(10);
        btn_left = 0; btn_right = 0; btn_up = 0; btn_down = 0; btn_color = 0;
        tick(10);
    endtask

    task automatic commit_chk(input string tag, input int ex, input int ey, input int ec,
                              input int hold);
        int pulses;
        vcount = 11'd479;
        tick(2);
        vcount = 11'd480;
        #1;
        chk({tag, "_fu_hi"}, frame_update, 1);
        @(posedge clk);
        #1;
        chk({tag, "_fu_lo"}, frame_update, 0);
        chk({tag, "_x"}, x, ex);
        chk({tag, "_y"}, y, ey);
        chk({tag, "_color"}, color, ec);
        pulses = 0;
        repeat (hold) begin
            @(negedge clk);
            #1;
            if (frame_update) pulses++;
        end
        chk({tag, "_one_pulse"}, pulses, 0);
        vcount = 11'd0;
        tick(2);
    endtask

    function automatic logic [7:0] next_col(input logic [7:0] c);
        logic [7:0] n;
        n = c + 8'h25;
        return (n == 8'h00) ? 8'h25 : n;
    endfunction

    initial begin
        logic [7:0] mcol;

        tbl[0] = '{0, 1, 0, 0, 0, 1, 0, 8'hE0};
        tbl[1] = '{1, 0, 0, 0, 0, 0, 0, 8'hE0};
        tbl[2] = '{1, 0, 1, 0, 0, 19, 14, 8'hE0};
        tbl[3] = '{0, 1, 0, 1, 0, 0, 0, 8'hE0};
        tbl[4] = '{1, 1, 0, 0, 0, 0, 0, 8'hE0};
        tbl[5] = '{0, 0, 1, 1, 1, 0, 0, 8'h05};
        tbl[6] = '{0, 0, 0, 1, 0, 0, 1, 8'h05};
        tbl[7] = '{0, 1, 0, 1, 1, 1, 2, 8'h2A};
        tbl[8] = '{0, 0, 0, 0, 0, 1, 2, 8'h2A};
        col_seq = '{8'hE0, 8'h05, 8'h2A, 8'h4F, 8'h74, 8'h99, 8'hBE, 8'hE3};

        rst_n = 0; vcount = 0;
        btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; btn_color = 0;
        tick(3);
        chk("rst_x", x, 0);
        chk("rst_y", y, 0);
        chk("rst_color", color, 8'hE0);
        chk("rst_fu", frame_update, 0);
        rst_n = 1;
        tick(2);

        // Bouncing input never stays stable long enough to register.
        for (int i = 0; i < 20; i++) begin
            btn_right = ~btn_right;
            tick(2);
        end
        btn_right = 0;
        tick(10);
        commit_chk("bounce", 0, 0, 8'hE0, 4);

        // Clean press, then the commit line is held for a long stretch.
        press(0, 1, 0, 0, 0);
        commit_chk("clean_hold", 1, 0, 8'hE0, 800);

        // Three presses in one frame give a single step.
        press(0, 1, 0, 0, 0);
        press(0, 1, 0, 0, 0);
        press(0, 1, 0, 0, 0);
        commit_chk("collapse", 2, 0, 8'hE0, 4);

        // Asynchronous reset mid-cycle.
        #2;
        rst_n = 0;
        #1;
        chk("arst_x", x, 0);
        chk("arst_y", y, 0);
        chk("arst_color", color, 8'hE0);
        chk("arst_fu", frame_update, 0);
        tick(2);
        rst_n = 1;
        tick(2);

        for (int i = 0; i < 9; i++) begin
            press(tbl[i].l, tbl[i].r, tbl[i].u, tbl[i].d, tbl[i].c);
            commit_chk($sformatf("vec%0d", i), tbl[i].ex, tbl[i].ey, tbl[i].ec, 4);
        end

        // Reset with flags pending and a press mid-debounce discards everything.
        press(0, 1, 0, 0, 1);
        btn_down = 1;
        tick(3);
        rst_n = 0;
        btn_down = 0;
        tick(2);
        rst_n = 1;
        tick(10);
        commit_chk("rst_pending", 0, 0, 8'hE0, 4);

        // Colour walk from reset; the 160th step would land on zero.
        mcol = 8'hE0;
        for (int k = 1; k <= 160; k++) begin
            press(0, 0, 0, 0, 1);
            mcol = next_col(mcol);
            commit_chk($sformatf("col%0d", k), 0, 0, mcol, 2);
            if (k <= 7) chk($sformatf("col_seq%0d", k), color, col_seq[k]);
            if (k == 159) chk("col_db", color, 8'hDB);
            if (k == 160) chk("col_skip0", color, 8'h25);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
